// File: rtl/fft_uart_frame_scheduler.sv
// Frame scheduler between a UART receiver, an FFT core and a UART transmitter:
// collects FFT_SIZE bytes, waits for the FFT, then sends header, 2*FFT_SIZE payload bytes and a checksum.
module fft_uart_frame_scheduler #(
  parameter int                     FFT_SIZE     = 32,
  parameter int                     DATA_LENGTH  = 8,
  parameter int                     GAP_TIMEOUT  = 4340,
  parameter int                     FFT_WATCHDOG = 1024,
  parameter logic [DATA_LENGTH-1:0] HEADER       = 8'hA5
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_rx_valid,
  input  logic                   i_fft_done,
  input  logic                   i_tx_done,
  input  logic [DATA_LENGTH-1:0] i_payload_byte,
  output logic                   o_fft_rst,
  output logic                   o_rx_block,
  output logic                   o_tx_enable,
  output logic                   o_tx_start,
  output logic [DATA_LENGTH-1:0] o_tx_byte,
  output logic [6:0]             o_sel,
  output logic                   o_busy,
  output logic                   o_err_timeout,
  output logic                   o_err_overrun
);

  localparam int RX_W  = $clog2(FFT_SIZE + 1);
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam int WD_W  = $clog2(FFT_WATCHDOG + 1);

  localparam logic [RX_W-1:0]  RX_LAST  = RX_W'(FFT_SIZE - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(FFT_WATCHDOG - 1);
  localparam logic [6:0]       SEL_LAST = 7'(2 * FFT_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    COMPUTE,
    TX_HDR,
    TX_PAYLOAD,
    TX_CSUM
  } state_t;

  state_t                 state;
  logic [RX_W-1:0]        rx_count;
  logic [GAP_W-1:0]       gap_cnt;
  logic [WD_W-1:0]        wdog_cnt;
  logic [DATA_LENGTH-1:0] checksum;
  logic                   tx_pending;
  logic                   in_blocked_state;

  assign in_blocked_state = (state != IDLE) && (state != RECEIVE);

  // Each TX byte takes a launch cycle (start pulse, byte latched) followed by a wait for
  // i_tx_done; the launch cycle lets i_payload_byte settle after o_sel changes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      rx_count      <= '0;
      gap_cnt       <= '0;
      wdog_cnt      <= '0;
      checksum      <= '0;
      tx_pending    <= 1'b0;
      o_fft_rst     <= 1'b1;
      o_rx_block    <= 1'b0;
      o_tx_enable   <= 1'b0;
      o_tx_start    <= 1'b0;
      o_tx_byte     <= '0;
      o_sel         <= '0;
      o_busy        <= 1'b0;
      o_err_timeout <= 1'b0;
      o_err_overrun <= 1'b0;
    end else begin
      o_tx_start    <= 1'b0;
      o_err_timeout <= 1'b0;
      o_err_overrun <= i_rx_valid && in_blocked_state;

      case (state)
        IDLE: begin
          if (i_rx_valid) begin
            state     <= RECEIVE;
            rx_count  <= RX_W'(1);
            gap_cnt   <= '0;
            o_fft_rst <= 1'b0;
            o_busy    <= 1'b1;
          end
        end

        RECEIVE: begin
          if (i_rx_valid) begin
            gap_cnt  <= '0;
            rx_count <= rx_count + RX_W'(1);
            if (rx_count == RX_LAST) begin
              state      <= COMPUTE;
              wdog_cnt   <= '0;
              o_rx_block <= 1'b1;
            end
          end else if (gap_cnt == GAP_LAST) begin
            state         <= IDLE;
            rx_count      <= '0;
            gap_cnt       <= '0;
            o_err_timeout <= 1'b1;
            o_fft_rst     <= 1'b1;
            o_busy        <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        // A done arriving on the same cycle as watchdog expiry still proceeds to transmit.
        COMPUTE: begin
          if (i_fft_done) begin
            state       <= TX_HDR;
            rx_count    <= '0;
            wdog_cnt    <= '0;
            checksum    <= '0;
            tx_pending  <= 1'b0;
            o_tx_enable <= 1'b1;
          end else if (wdog_cnt == WD_LAST) begin
            state         <= IDLE;
            rx_count      <= '0;
            wdog_cnt      <= '0;
            o_err_timeout <= 1'b1;
            o_fft_rst     <= 1'b1;
            o_rx_block    <= 1'b0;
            o_busy        <= 1'b0;
          end else begin
            wdog_cnt <= wdog_cnt + WD_W'(1);
          end
        end

        TX_HDR: begin
          if (!tx_pending) begin
            tx_pending <= 1'b1;
            o_tx_start <= 1'b1;
            o_tx_byte  <= HEADER;
          end else if (i_tx_done) begin
            tx_pending <= 1'b0;
            state      <= TX_PAYLOAD;
          end
        end

        TX_PAYLOAD: begin
          if (!tx_pending) begin
            tx_pending <= 1'b1;
            o_tx_start <= 1'b1;
            o_tx_byte  <= i_payload_byte;
            checksum   <= checksum + i_payload_byte;
          end else if (i_tx_done) begin
            tx_pending <= 1'b0;
            if (o_sel == SEL_LAST) begin
              state <= TX_CSUM;
            end else begin
              o_sel <= o_sel + 7'd1;
            end
          end
        end

        TX_CSUM: begin
          if (!tx_pending) begin
            tx_pending <= 1'b1;
            o_tx_start <= 1'b1;
            o_tx_byte  <= checksum;
          end else if (i_tx_done) begin
            tx_pending  <= 1'b0;
            state       <= IDLE;
            o_sel       <= '0;
            o_fft_rst   <= 1'b1;
            o_rx_block  <= 1'b0;
            o_tx_enable <= 1'b0;
            o_busy      <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          tx_pending  <= 1'b0;
          o_sel       <= '0;
          o_fft_rst   <= 1'b1;
          o_rx_block  <= 1'b0;
          o_tx_enable <= 1'b0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_uart_frame_scheduler.sv
// Directed bench for fft_uart_frame_scheduler: reset/idle vector table, then nominal,
// gap, watchdog, overrun, spurious-handshake and mid-frame reset sequences.
module tb_fft_uart_frame_scheduler;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_rx_valid;
  logic       i_fft_done;
  logic       i_tx_done;
  logic [7:0] i_payload_byte;
  logic       o_fft_rst;
  logic       o_rx_block;
  logic       o_tx_enable;
  logic       o_tx_start;
  logic [7:0] o_tx_byte;
  logic [6:0] o_sel;
  logic       o_busy;
  logic       o_err_timeout;
  logic       o_err_overrun;

  logic [7:0] payload_xor;
  int         checks;
  int         failures;

  logic [7:0] got_bytes[$];
  int         first_start_cyc;
  bit         overrun_seen;

  typedef struct {
    logic rx, done, txd;
    logic busy, fft_rst, rx_block, tx_en, tx_start;
  } vec_t;

  vec_t vecs[6];

  assign i_payload_byte = {1'b0, o_sel} ^ payload_xor;

  fft_uart_frame_scheduler dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_rx_valid     (i_rx_valid),
    .i_fft_done     (i_fft_done),
    .i_tx_done      (i_tx_done),
    .i_payload_byte (i_payload_byte),
    .o_fft_rst      (o_fft_rst),
    .o_rx_block     (o_rx_block),
    .o_tx_enable    (o_tx_enable),
    .o_tx_start     (o_tx_start),
    .o_tx_byte      (o_tx_byte),
    .o_sel          (o_sel),
    .o_busy         (o_busy),
    .o_err_timeout  (o_err_timeout),
    .o_err_overrun  (o_err_overrun)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_rx_valid = v.rx;
    i_fft_done = v.done;
    i_tx_done  = v.txd;
    @(negedge i_clk);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_fft_rst"},  o_fft_rst,     1);
    checkOutput({tag, "_rx_block"}, o_rx_block,    0);
    checkOutput({tag, "_tx_en"},    o_tx_enable,   0);
    checkOutput({tag, "_tx_start"}, o_tx_start,    0);
    checkOutput({tag, "_tx_byte"},  o_tx_byte,     0);
    checkOutput({tag, "_sel"},      o_sel,         0);
    checkOutput({tag, "_busy"},     o_busy,        0);
    checkOutput({tag, "_timeout"},  o_err_timeout, 0);
    checkOutput({tag, "_overrun"},  o_err_overrun, 0);
  endtask

  // Pulses n rx bytes `spacing` cycles apart; returns just after the negedge following the last pulse.
  task automatic send_frame(input int n, input int spacing);
    for (int i = 0; i < n; i++) begin
      i_rx_valid = 1'b1;
      @(negedge i_clk);
      i_rx_valid = 1'b0;
      if (i != n - 1) repeat (spacing - 1) @(negedge i_clk);
    end
  endtask

  // Plays the UART TX side: answers each start with tx_done 5 cycles later.
  task automatic collect_tx(input int stop_sel, input bit inject_overrun, input bit extra_done);
    int  countdown;
    int  cyc;
    bit  extra_pending;
    bit  injected;
    bit  check_ovr;
    bit  finished;
    countdown = -1;
    extra_pending = 0;
    injected = 0;
    check_ovr = 0;
    finished = 0;
    got_bytes.delete();
    first_start_cyc = -1;
    overrun_seen = 0;
    for (cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge i_clk);
      i_tx_done  = 1'b0;
      i_rx_valid = 1'b0;
      if (o_err_overrun) overrun_seen = 1;
      if (check_ovr) begin
        checkOutput("overrun_pulse", o_err_overrun, 1);
        checkOutput("overrun_sel_hold", o_sel, 10);
        check_ovr = 0;
      end
      if (o_tx_start) begin
        got_bytes.push_back(o_tx_byte);
        if (first_start_cyc < 0) first_start_cyc = cyc;
        countdown = 5;
        if (stop_sel >= 0 && int'(o_sel) == stop_sel && got_bytes.size() > 1) begin
          finished = 1;
          break;
        end
      end else if (countdown > 0) begin
        countdown--;
      end
      if (got_bytes.size() > 0 && !o_busy) begin
        finished = 1;
        break;
      end
      if (extra_pending) begin
        i_tx_done = 1'b1;
        extra_pending = 0;
      end else if (countdown == 0) begin
        i_tx_done = 1'b1;
        countdown = -1;
        extra_pending = extra_done;
      end
      if (inject_overrun && !injected && o_sel == 7'd10 && countdown == 3) begin
        i_rx_valid = 1'b1;
        injected = 1;
        check_ovr = 1;
      end
    end
    if (!finished) checkOutput("tx_collect_budget", 0, 1);
    i_tx_done  = 1'b0;
    i_rx_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] x);
    logic [7:0] csum;
    csum = 8'h00;
    for (int i = 0; i < 64; i++) csum = csum + (8'(i) ^ x);
    checkOutput({tag, "_starts"}, got_bytes.size(), 66);
    if (got_bytes.size() == 66) begin
      checkOutput({tag, "_hdr"}, got_bytes[0], 8'hA5);
      for (int i = 0; i < 64; i++)
        checkOutput($sformatf("%s_pay%0d", tag, i), got_bytes[i+1], 8'(i) ^ x);
      checkOutput({tag, "_csum"}, got_bytes[65], csum);
    end
    checkOutput({tag, "_end_busy"},    o_busy,      0);
    checkOutput({tag, "_end_fft_rst"}, o_fft_rst,   1);
    checkOutput({tag, "_end_sel"},     o_sel,       0);
    checkOutput({tag, "_end_tx_en"},   o_tx_enable, 0);
  endtask

  initial begin
    int k;
    int seen;
    int starts;
    checks      = 0;
    failures    = 0;
    payload_xor = 8'h00;
    i_rst_n     = 1'b1;
    i_rx_valid  = 1'b0;
    i_fft_done  = 1'b0;
    i_tx_done   = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    #2 i_rst_n = 1'b0;
    #1 check_reset_values("por");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    $display("[TB] idle/receive vector table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_busy", i),     o_busy,      vecs[i].busy);
      checkOutput($sformatf("vec%0d_fft_rst", i),  o_fft_rst,   vecs[i].fft_rst);
      checkOutput($sformatf("vec%0d_rx_block", i), o_rx_block,  vecs[i].rx_block);
      checkOutput($sformatf("vec%0d_tx_en", i),    o_tx_enable, vecs[i].tx_en);
      checkOutput($sformatf("vec%0d_tx_start", i), o_tx_start,  vecs[i].tx_start);
    end
    i_rx_valid = 1'b0;
    i_fft_done = 1'b0;
    i_tx_done  = 1'b0;
    #2 i_rst_n = 1'b0;
    #1 check_reset_values("rst_recv");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    $display("[TB] nominal frame with overrun and spurious tx_done");
    send_frame(32, 10);
    checkOutput("nom_compute_busy",    o_busy,      1);
    checkOutput("nom_compute_block",   o_rx_block,  1);
    checkOutput("nom_compute_fft_rst", o_fft_rst,   0);
    checkOutput("nom_compute_tx_en",   o_tx_enable, 0);
    starts = 0;
    for (int c = 0; c < 50; c++) begin
      i_tx_done = (c == 20);
      @(negedge i_clk);
      if (o_tx_start) starts++;
    end
    i_tx_done = 1'b0;
    checkOutput("nom_compute_no_start", starts, 0);
    checkOutput("nom_compute_hold", o_rx_block && !o_tx_enable && o_busy, 1);
    i_fft_done = 1'b1;
    @(negedge i_clk);
    i_fft_done = 1'b0;
    collect_tx(-1, 1, 1);
    checkOutput("nom_latency", first_start_cyc, 1);
    checkOutput("nom_overrun_seen", overrun_seen, 1);
    if (got_bytes.size() == 66) checkOutput("nom_csum_e0", got_bytes[65], 8'hE0);
    check_frame("nom", 8'h00);

    $display("[TB] rx gap timeout");
    send_frame(5, 3);
    seen = -1;
    starts = 0;
    for (k = 1; k <= 4400; k++) begin
      @(negedge i_clk);
      if (o_tx_start) starts++;
      if (o_err_timeout) begin
        seen = k;
        break;
      end
    end
    checkOutput("gap_cycles", seen, 4340);
    checkOutput("gap_busy", o_busy, 0);
    checkOutput("gap_fft_rst", o_fft_rst, 1);
    checkOutput("gap_no_start", starts, 0);
    @(negedge i_clk);
    checkOutput("gap_pulse_width", o_err_timeout, 0);

    $display("[TB] fft watchdog");
    send_frame(32, 2);
    seen = -1;
    for (k = 1; k <= 1100; k++) begin
      @(negedge i_clk);
      if (o_err_timeout) begin
        seen = k;
        break;
      end
    end
    checkOutput("wd_cycles", seen, 1024);
    checkOutput("wd_busy", o_busy, 0);
    checkOutput("wd_fft_rst", o_fft_rst, 1);
    checkOutput("wd_rx_block", o_rx_block, 0);
    @(negedge i_clk);

    $display("[TB] done coincident with watchdog expiry");
    payload_xor = 8'h5A;
    send_frame(32, 2);
    repeat (1023) @(negedge i_clk);
    i_fft_done = 1'b1;
    @(negedge i_clk);
    i_fft_done = 1'b0;
    checkOutput("wdc_no_timeout", o_err_timeout, 0);
    checkOutput("wdc_busy", o_busy, 1);
    checkOutput("wdc_tx_en", o_tx_enable, 1);
    collect_tx(-1, 0, 0);
    check_frame("wdc", 8'h5A);

    $display("[TB] reset at o_sel=20");
    payload_xor = 8'h00;
    send_frame(32, 3);
    i_fft_done = 1'b1;
    @(negedge i_clk);
    i_fft_done = 1'b0;
    collect_tx(20, 0, 0);
    checkOutput("mid_sel_reached", o_sel, 20);
    #2 i_rst_n = 1'b0;
    #1 check_reset_values("rst_mid");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    $display("[TB] fresh frame after reset, level fft_done");
    payload_xor = 8'h33;
    i_fft_done = 1'b1;
    send_frame(32, 4);
    collect_tx(-1, 0, 0);
    i_fft_done = 1'b0;
    checkOutput("fresh_latency", first_start_cyc, 2);
    check_frame("fresh", 8'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
